ext_crc: RTL and testbench

Receive-path byte-stream filter that removes the 4-byte Ethernet FCS (CRC) from each incoming frame. It sits directly behind the PHY/MAC receive byte interface, one byte per `rx_clk`. It optionally discards preamble and SFD. It emits only the payload bytes with a qualifying enable. The CRC value is not checked, only stripped.

---
 rtl/ext_crc_if.sv | 19 +
 rtl/ext_crc.sv | 112 +++++++++++
 tb/tb_ext_crc.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_crc_if.sv
// Receive byte-stream bundle between the MAC/PHY side and the FCS stripper.
// master drives the receive bytes; slave (the stripper) returns the payload.
interface ext_crc_if;
    logic [7:0] rx_data;
    logic       rx_enable;
    logic       sfd_wait;
    logic [7:0] rawdata;
    logic       raw_en;

    modport master (
        output rx_data, rx_enable, sfd_wait,
        input  rawdata, raw_en
    );

    modport slave (
        input  rx_data, rx_enable, sfd_wait,
        output rawdata, raw_en
    );
endinterface

// File: rtl/ext_crc.sv
// Receive-path filter: optionally drops preamble/SFD, then withholds the last
// CRC_BYTES bytes of every frame so only payload reaches rawdata/raw_en.
module ext_crc #(
    parameter int unsigned CRC_BYTES = 4
) (
    input  logic     rx_clk,
    input  logic     rst,
    ext_crc_if.slave bus
);

    localparam int unsigned      CNT_W   = $clog2(CRC_BYTES + 1);
    localparam int unsigned      SR_W    = CRC_BYTES * 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CRC_BYTES);
    localparam logic [7:0]       SFD     = 8'hD5;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        DATA
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [SR_W-1:0]  shreg;       // byte 0 = newest, top byte = oldest
    logic             push;
    logic             emit;
    logic [7:0]       rawdata_q;
    logic             raw_en_q;

    // NOTE: every signal written here is given a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        count_next = count;
        push       = 1'b0;
        emit       = 1'b0;

        if (!bus.rx_enable) begin
            // Whatever is still in the shift register is the FCS; it is simply
            // abandoned by clearing the fill count.
            state_next = IDLE;
            count_next = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.sfd_wait) begin
                        state_next = (bus.rx_data == SFD) ? DATA : HUNT;
                    end else begin
                        push       = 1'b1;
                        state_next = DATA;
                    end
                end
                HUNT: begin
                    if (bus.rx_data == SFD) begin
                        state_next = DATA;
                    end
                end
                DATA: begin
                    push = 1'b1;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase

            if (push) begin
                if (count == CNT_MAX) begin
                    emit = 1'b1;
                end else begin
                    count_next = count + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // NOTE: the shift register is a handful of flops with a defined reset
    // value, so it is cleared along with the control state; large RAM-style
    // storage would normally be left without reset.
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            shreg     <= '0;
            rawdata_q <= 8'h00;
            raw_en_q  <= 1'b0;
        end else begin
            raw_en_q <= emit;
            if (emit) begin
                rawdata_q <= shreg[SR_W-1 -: 8];
            end
            if (push) begin
                shreg <= SR_W'({shreg, bus.rx_data});
            end
        end
    end

    assign bus.rawdata = rawdata_q;
    assign bus.raw_en  = raw_en_q;

endmodule

// File: tb/tb_ext_crc.sv
// Self-checking bench for ext_crc: directed frames from the test plan plus
// randomized frames compared against a frame-level reference model.
module tb_ext_crc;

    localparam int CRC_BYTES = 4;

    typedef logic [7:0] bq_t[$];

    logic rx_clk = 1'b0;
    logic rst    = 1'b1;

    ext_crc_if bus ();

    ext_crc #(.CRC_BYTES(CRC_BYTES)) dut (
        .rx_clk (rx_clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 rx_clk = ~rx_clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [7:0] got_data[$];
    int         got_edge[$];
    logic [7:0] exp_data[$];
    int         exp_edge[$];

    // Edge counter: value seen at a negedge is the number of the last posedge.
    always @(posedge rx_clk) cyc <= cyc + 1;

    always @(negedge rx_clk) begin
        if (bus.raw_en === 1'b1) begin
            got_data.push_back(bus.rawdata);
            got_edge.push_back(cyc);
        end
    end

    // Reference: strip preamble up to and including the first 0xD5 when the
    // frame starts with sfd_wait set; payload byte k must appear registered
    // CRC_BYTES edges after it was sampled, and the last CRC_BYTES never appear.
    task automatic model_frame(input bq_t f, input bit sfd, input int e0);
        bit         hunting = sfd;
        logic [7:0] pay[$];
        int         pe[$];
        foreach (f[i]) begin
            if (hunting) begin
                if (f[i] == 8'hD5) hunting = 1'b0;
            end else begin
                pay.push_back(f[i]);
                pe.push_back(e0 + i);
            end
        end
        for (int k = 0; k + CRC_BYTES < pay.size(); k++) begin
            exp_data.push_back(pay[k]);
            exp_edge.push_back(pe[k] + CRC_BYTES);
        end
    endtask

    // Drives one frame (optionally with rst pulsed on byte rst_at), then gap
    // idle cycles, and compares everything emitted against the model.
    task automatic run_frame(input string name, input bq_t f, input bit sfd,
                             input bit jitter_sfd, input int gap, input int rst_at);
        int e0 = 0;
        bit prev_rst = 1'b0;
        bit sfd_drv[$];
        got_data.delete(); got_edge.delete();
        exp_data.delete(); exp_edge.delete();
        for (int i = 0; i < f.size(); i++) begin
            @(negedge rx_clk);
            if (prev_rst) begin
                tests_run++;
                if (bus.raw_en !== 1'b0 || bus.rawdata !== 8'h00) begin
                    tests_failed++;
                    $display("FAIL %s reset_out: got en=%b data=%h expected en=0 data=00",
                             name, bus.raw_en, bus.rawdata);
                end
            end
            if (i == 0) e0 = cyc + 1;
            bus.rx_enable = 1'b1;
            bus.rx_data   = f[i];
            bus.sfd_wait  = (i == 0 || !jitter_sfd) ? sfd : 1'($urandom_range(1));
            sfd_drv.push_back(bus.sfd_wait);
            rst           = (i == rst_at);
            prev_rst      = rst;
        end
        @(negedge rx_clk);
        bus.rx_enable = 1'b0;
        rst           = 1'b0;
        repeat (gap) @(negedge rx_clk);

        if (rst_at > 0 && rst_at < f.size() - 1) begin
            model_frame(f[0:rst_at-1], sfd, e0);
            model_frame(f[rst_at+1:$], sfd_drv[rst_at+1], e0 + rst_at + 1);
        end else begin
            model_frame(f, sfd, e0);
        end

        tests_run++;
        if (got_data.size() !== exp_data.size()) begin
            tests_failed++;
            $display("FAIL %s count: got %0d bytes expected %0d", name,
                     got_data.size(), exp_data.size());
        end else begin
            foreach (exp_data[k]) begin
                tests_run++;
                if (got_data[k] !== exp_data[k] || got_edge[k] !== exp_edge[k]) begin
                    tests_failed++;
                    $display("FAIL %s byte%0d: got %h@edge%0d expected %h@edge%0d", name,
                             k, got_data[k], got_edge[k], exp_data[k], exp_edge[k]);
                end
            end
        end
        tests_run++;
        if (bus.raw_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s idle_en: got %b expected 0", name, bus.raw_en);
        end
    endtask

    task automatic check_byte(input string name, input int idx, input logic [7:0] want);
        tests_run++;
        if (idx >= got_data.size()) begin
            tests_failed++;
            $display("FAIL %s pos%0d: got nothing expected %h", name, idx, want);
        end else if (got_data[idx] !== want) begin
            tests_failed++;
            $display("FAIL %s pos%0d: got %h expected %h", name, idx, got_data[idx], want);
        end
    endtask

    task automatic check_count(input string name, input int want);
        tests_run++;
        if (got_data.size() != want) begin
            tests_failed++;
            $display("FAIL %s total: got %0d expected %0d", name, got_data.size(), want);
        end
    endtask

    function automatic bq_t pattern50(input logic [7:0] b5, b6, b7, b10);
        bq_t f;
        for (int i = 0; i < 50; i++) f.push_back(8'h55);
        f[5] = b5;  f[6] = b6;  f[7] = b7;  f[10] = b10;
        f[45] = 8'h03; f[46] = 8'h02; f[47] = 8'h01; f[48] = 8'h00; f[49] = 8'h0F;
        return f;
    endfunction

    function automatic bq_t ramp(input logic [7:0] start, input int n);
        bq_t f;
        for (int i = 0; i < n; i++) f.push_back(start + 8'(i));
        return f;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge rx_clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge rx_clk);
            tests_run++;
            if (bus.raw_en !== 1'b0 || bus.rawdata !== 8'h00) begin
                tests_failed++;
                $display("FAIL reset_idle cycle%0d: got en=%b data=%h expected en=0 data=00",
                         i, bus.raw_en, bus.rawdata);
            end
        end
    endtask

    task automatic test_frames_back_to_back();
        run_frame("frame1", pattern50(8'h00, 8'h02, 8'h01, 8'h03), 1'b0, 1'b0, 7, -1);
        check_count("frame1", 46);
        check_byte("frame1", 4, 8'h55);
        check_byte("frame1", 5, 8'h00);
        check_byte("frame1", 6, 8'h02);
        check_byte("frame1", 7, 8'h01);
        check_byte("frame1", 10, 8'h03);
        check_byte("frame1", 45, 8'h03);
        run_frame("frame2", pattern50(8'h00, 8'h04, 8'h05, 8'h06), 1'b0, 1'b0, 2, -1);
        check_count("frame2", 46);
        check_byte("frame2", 6, 8'h04);
        check_byte("frame2", 7, 8'h05);
        check_byte("frame2", 10, 8'h06);
    endtask

    task automatic test_sfd();
        bq_t f;
        for (int i = 0; i < 7; i++) f.push_back(8'h55);
        f.push_back(8'hD5);
        f = {f, ramp(8'h10, 10)};
        run_frame("sfd", f, 1'b1, 1'b0, 2, -1);
        check_count("sfd", 6);
        check_byte("sfd", 0, 8'h10);
        check_byte("sfd", 5, 8'h15);
    endtask

    task automatic test_short();
        run_frame("short4", ramp(8'hB0, 4), 1'b0, 1'b0, 2, -1);
        check_count("short4", 0);
        run_frame("short5", ramp(8'hA0, 5), 1'b0, 1'b0, 2, -1);
        check_count("short5", 1);
        check_byte("short5", 0, 8'hA0);
    endtask

    task automatic test_abort();
        run_frame("abort", ramp(8'h01, 8), 1'b0, 1'b0, 1, -1);
        check_count("abort", 4);
        check_byte("abort", 3, 8'h04);
        run_frame("after_abort", ramp(8'hA0, 5), 1'b0, 1'b0, 2, -1);
        check_count("after_abort", 1);
    endtask

    task automatic test_mid_reset();
        run_frame("mid_reset", ramp(8'h30, 16), 1'b0, 1'b0, 2, 7);
        check_count("mid_reset", 7);
        check_byte("mid_reset", 3, 8'h38);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            bq_t f;
            bit  sfd = 1'($urandom_range(1));
            if (sfd) begin
                int p = $urandom_range(8);
                for (int i = 0; i < p; i++) begin
                    logic [7:0] b = 8'($urandom);
                    if (b == 8'hD5) b = 8'h55;
                    f.push_back(b);
                end
                if ($urandom_range(9) != 0) f.push_back(8'hD5);
            end
            for (int i = $urandom_range(20); i > 0; i--) f.push_back(8'($urandom));
            if (f.size() == 0) f.push_back(8'h55);
            run_frame($sformatf("rand%0d", n), f, sfd, 1'b1, $urandom_range(1, 3),
                      ($urandom_range(7) == 0) ? int'($urandom_range(1, 12)) : -1);
        end
    endtask

    initial begin
        bus.rx_enable = 1'b0;
        bus.rx_data   = 8'h00;
        bus.sfd_wait  = 1'b0;
        test_reset();
        test_frames_back_to_back();
        test_sfd();
        test_short();
        test_abort();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
